// File: rtl/ldpc_3gpp_enc_row_sched.sv
// Row scheduler for the fixed-mode 3GPP LDPC encoder: walks Hb rows, captures the
// registered 22-column descriptors from the table stage and streams unmasked columns out.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for istart
// SET_ROW | orow presented to the table stage
// WAIT    | table stage output registered and valid
// LOAD    | capture row descriptors and build the column mask
// SCAN    | emit one descriptor per unmasked column over valid/ready
// DONE    | one-cycle completion pulse
module ldpc_3gpp_enc_row_sched #(
    parameter int pROW_W = 6,
    parameter int pCOL_W = 5,
    parameter int pWSH_W = 8,
    parameter int pBSH_W = 6
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 iclkena,
    input  logic                 istart,
    input  logic                 iclear,
    input  logic [pROW_W-1:0]    iused_row,
    input  logic [pCOL_W-1:0]    iused_col,
    input  logic [22*pWSH_W-1:0] iac_wshift,
    input  logic [22*pBSH_W-1:0] iac_bshift,
    input  logic [21:0]          iac_masked,
    output logic [pROW_W-1:0]    orow,
    output logic                 oval,
    input  logic                 irdy,
    output logic                 osop,
    output logic                 oeop,
    output logic [pROW_W-1:0]    orow_num,
    output logic [pCOL_W-1:0]    ocol,
    output logic [pWSH_W-1:0]    owshift,
    output logic [pBSH_W-1:0]    obshift,
    output logic                 omasked,
    output logic                 obusy,
    output logic                 odone
);

    localparam int NCOL = 22;

    typedef enum logic [2:0] {IDLE, SET_ROW, WAIT, LOAD, SCAN, DONE} state_t;

    state_t              state, state_nxt;
    logic [pROW_W-1:0]   row_q;
    logic [pROW_W-1:0]   used_row_q;
    logic [pCOL_W-1:0]   used_col_q;
    logic [pCOL_W-1:0]   ptr_q;
    logic                sop_q;
    logic [NCOL-1:0]     msk_q;
    logic [pWSH_W-1:0]   wsh_q [NCOL];
    logic [pBSH_W-1:0]   bsh_q [NCOL];

    logic [NCOL-1:0]     avail;
    logic [NCOL-1:0]     rest;
    logic [pCOL_W-1:0]   sel;
    logic                found;
    logic                scan_eop;
    logic                xfer;

    // Lowest unmasked column at or above the scan pointer; rest tells whether it is the last.
    always_comb begin
        avail = '0;
        sel   = '0;
        for (int c = 0; c < NCOL; c++) begin
            avail[c] = ~msk_q[c] && (c >= int'(ptr_q));
        end
        for (int c = NCOL - 1; c >= 0; c--) begin
            if (avail[c]) begin
                sel = pCOL_W'(c);
            end
        end
        found     = |avail;
        rest      = avail;
        rest[sel] = 1'b0;
        scan_eop  = ~|rest;
    end

    assign xfer = (state == SCAN) && irdy;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (istart) state_nxt = SET_ROW;
            SET_ROW: state_nxt = WAIT;
            WAIT:    state_nxt = LOAD;
            LOAD:    state_nxt = SCAN;
            SCAN: begin
                if (xfer && scan_eop) begin
                    state_nxt = (row_q == used_row_q) ? DONE : SET_ROW;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (iclear) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state      <= IDLE;
            row_q      <= '0;
            used_row_q <= '0;
            used_col_q <= '0;
            ptr_q      <= '0;
            sop_q      <= 1'b0;
            msk_q      <= '0;
            for (int c = 0; c < NCOL; c++) begin
                wsh_q[c] <= '0;
                bsh_q[c] <= '0;
            end
        end else if (iclkena) begin
            state <= state_nxt;
            if (iclear) begin
                row_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (istart) begin
                            used_row_q <= iused_row;
                            used_col_q <= iused_col;
                            row_q      <= '0;
                        end
                    end
                    LOAD: begin
                        for (int c = 0; c < NCOL; c++) begin
                            msk_q[c] <= iac_masked[c] | (c >= int'(used_col_q));
                            wsh_q[c] <= iac_wshift[c*pWSH_W +: pWSH_W];
                            bsh_q[c] <= iac_bshift[c*pBSH_W +: pBSH_W];
                        end
                        ptr_q <= '0;
                        sop_q <= 1'b1;
                    end
                    SCAN: begin
                        if (xfer) begin
                            ptr_q <= sel + pCOL_W'(1);
                            sop_q <= 1'b0;
                            if (scan_eop && (row_q != used_row_q)) begin
                                row_q <= row_q + pROW_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Descriptor fields are forced to zero outside SCAN; a fully masked row yields a marker.
    assign orow     = row_q;
    assign oval     = (state == SCAN);
    assign osop     = oval & sop_q;
    assign oeop     = oval & scan_eop;
    assign orow_num = oval ? row_q : '0;
    assign omasked  = oval & ~found;
    assign ocol     = (oval && found) ? sel : '0;
    assign owshift  = (oval && found) ? wsh_q[sel] : '0;
    assign obshift  = (oval && found) ? bsh_q[sel] : '0;
    assign obusy    = (state != IDLE);
    assign odone    = (state == DONE);

endmodule

// File: tb/tb_ldpc_3gpp_enc_row_sched.sv
// Directed bench for the LDPC row scheduler with a registered table-stage model.
module tb_ldpc_3gpp_enc_row_sched;

    logic         iclk;
    logic         ireset;
    logic         iclkena;
    logic         istart;
    logic         iclear;
    logic [5:0]   iused_row;
    logic [4:0]   iused_col;
    logic [175:0] iac_wshift;
    logic [131:0] iac_bshift;
    logic [21:0]  iac_masked;
    logic [5:0]   orow;
    logic         oval;
    logic         irdy;
    logic         osop;
    logic         oeop;
    logic [5:0]   orow_num;
    logic [4:0]   ocol;
    logic [7:0]   owshift;
    logic [5:0]   obshift;
    logic         omasked;
    logic         obusy;
    logic         odone;

    ldpc_3gpp_enc_row_sched dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .iclkena    (iclkena),
        .istart     (istart),
        .iclear     (iclear),
        .iused_row  (iused_row),
        .iused_col  (iused_col),
        .iac_wshift (iac_wshift),
        .iac_bshift (iac_bshift),
        .iac_masked (iac_masked),
        .orow       (orow),
        .oval       (oval),
        .irdy       (irdy),
        .osop       (osop),
        .oeop       (oeop),
        .orow_num   (orow_num),
        .ocol       (ocol),
        .owshift    (owshift),
        .obshift    (obshift),
        .omasked    (omasked),
        .obusy      (obusy),
        .odone      (odone)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    int          n_vec = 0;
    int          n_err = 0;
    int          first_oval;
    int          done_cyc;
    int          n_desc;
    logic [21:0] tbl_mask [46];
    logic [27:0] exp_q [$];

    function automatic logic [7:0] tw(input int r, input int c);
        return 8'((r * 37 + c * 11 + 5) % 256);
    endfunction

    function automatic logic [5:0] tbs(input int r, input int c);
        return 6'((r * 13 + c * 7 + 1) % 64);
    endfunction

    function automatic logic [27:0] pack(input logic [5:0] r, input logic [4:0] c,
                                         input logic [7:0] w, input logic [5:0] b,
                                         input logic m, input logic s, input logic e);
        return {r, c, w, b, m, s, e};
    endfunction

    // Table stage: registers the row descriptors one cycle after orow.
    always @(posedge iclk) begin
        if (iclkena) begin
            for (int c = 0; c < 22; c++) begin
                iac_wshift[c*8 +: 8] <= tw(int'(orow), c);
                iac_bshift[c*6 +: 6] <= tbs(int'(orow), c);
            end
            iac_masked <= tbl_mask[orow];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic build_exp(input int ur, input int uc);
        int  last;
        bit  first;
        exp_q.delete();
        for (int r = 0; r <= ur; r++) begin
            last = -1;
            for (int c = 0; c < uc; c++) if (!tbl_mask[r][c]) last = c;
            if (last < 0) begin
                exp_q.push_back(pack(6'(r), 5'd0, 8'd0, 6'd0, 1'b1, 1'b1, 1'b1));
            end else begin
                first = 1'b1;
                for (int c = 0; c < uc; c++) begin
                    if (!tbl_mask[r][c]) begin
                        exp_q.push_back(pack(6'(r), 5'(c), tw(r, c), tbs(r, c), 1'b0,
                                             first, c == last));
                        first = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic run_pass(input int ur, input int uc, input bit rnd, input bit start_in_done);
        logic [27:0] cur;
        logic [27:0] saved;
        logic [27:0] e;
        bit          stalled;
        int          m;
        int          done_cnt;
        build_exp(ur, uc);
        iused_row = 6'(ur);
        iused_col = 5'(uc);
        istart    = 1'b1;
        irdy      = 1'b1;
        step();
        istart    = 1'b0;
        iused_row = 6'd45;
        iused_col = 5'd3;
        m = 1; first_oval = -1; done_cyc = -1; done_cnt = 0; n_desc = 0;
        stalled = 1'b0; saved = '0;
        while (done_cnt == 0 && m < 3000) begin
            cur = pack(orow_num, ocol, owshift, obshift, omasked, osop, oeop);
            if (oval && first_oval < 0) first_oval = m;
            if (stalled) chk("stall_hold", 64'(cur), 64'(saved));
            if (odone) begin
                done_cnt++;
                done_cyc = m;
                if (start_in_done) istart = 1'b1;
            end
            if (oval) begin
                irdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (irdy) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_desc", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("desc", 64'(cur), 64'(e));
                        if (osop) chk("orow", 64'(orow), 64'(e[27:22]));
                    end
                    n_desc++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    saved   = cur;
                end
            end
            step();
            m++;
            istart = 1'b0;
        end
        chk("done_seen", 64'(done_cnt), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_after", 64'({obusy, oval, odone}), 64'd0);
    endtask

    initial begin
        logic [27:0] cur;
        logic [27:0] saved;
        int          guard;
        for (int r = 0; r < 46; r++) tbl_mask[r] = '0;
        ireset = 1'b0; iclkena = 1'b1; istart = 1'b0; iclear = 1'b0; irdy = 1'b0;
        iused_row = '0; iused_col = '0;
        #12;
        chk("reset_outs", 64'({orow, oval, osop, oeop, orow_num, ocol, owshift, obshift,
                               omasked, obusy, odone}), 64'd0);
        ireset = 1'b1;
        step();

        // BG1: one row of 22 unmasked columns; istart pulsed during DONE must be ignored
        run_pass(0, 22, 1'b0, 1'b1);
        chk("bg1_first_oval", 64'(first_oval), 64'd4);
        chk("bg1_done_cyc", 64'(done_cyc), 64'd26);
        chk("bg1_count", 64'(n_desc), 64'd22);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("start_in_done_ignored", 64'({obusy, oval}), 64'd0);
        end

        // BG2: 10 information columns, cols 1,4,9 masked, col 15 masked but out of range anyway
        tbl_mask[0] = 22'h008212;
        run_pass(0, 10, 1'b0, 1'b0);
        chk("bg2_count", 64'(n_desc), 64'd7);

        // Fully masked row 2 inside a 4-row pass
        tbl_mask[0] = 22'h000000;
        tbl_mask[1] = 22'h2AAAAA;
        tbl_mask[2] = 22'h3FFFFF;
        tbl_mask[3] = 22'h000001;
        run_pass(3, 22, 1'b0, 1'b0);
        chk("masked_row_count", 64'(n_desc), 64'd55);

        // Random back-pressure across 4 rows
        tbl_mask[0] = 22'h155555;
        tbl_mask[1] = 22'h3FFFFE;
        tbl_mask[2] = 22'h1FFFFF;
        tbl_mask[3] = 22'h000000;
        run_pass(3, 22, 1'b1, 1'b0);
        chk("stall_count", 64'(n_desc), 64'd35);

        // iclear mid-row 1 while stalled, after a clock-enable freeze
        for (int r = 0; r < 4; r++) tbl_mask[r] = '0;
        iused_row = 6'd3; iused_col = 5'd22; istart = 1'b1; irdy = 1'b1;
        step();
        istart = 1'b0;
        guard = 0;
        while (!(oval && orow_num == 6'd1 && !osop) && guard < 200) begin
            step();
            guard++;
        end
        chk("reach_row1", 64'(guard < 200), 64'd1);
        saved = pack(orow_num, ocol, owshift, obshift, omasked, osop, oeop);
        iclkena = 1'b0;
        irdy    = 1'b1;
        step();
        step();
        cur = pack(orow_num, ocol, owshift, obshift, omasked, osop, oeop);
        chk("clkena_hold", 64'(cur), 64'(saved));
        chk("clkena_busy", 64'({obusy, oval}), 64'd3);
        iclkena = 1'b1;
        irdy    = 1'b0;
        iclear  = 1'b1;
        step();
        iclear = 1'b0;
        chk("clear_oval", 64'(oval), 64'd0);
        chk("clear_busy", 64'(obusy), 64'd0);
        chk("clear_done", 64'(odone), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("clear_quiet", 64'({obusy, odone}), 64'd0);
        end
        run_pass(1, 22, 1'b0, 1'b0);
        chk("restart_first_oval", 64'(first_oval), 64'd4);
        chk("restart_count", 64'(n_desc), 64'd44);

        // Asynchronous reset in the middle of SCAN
        iused_row = 6'd2; iused_col = 5'd22; istart = 1'b1; irdy = 1'b1;
        step();
        istart = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("pre_reset_oval", 64'(oval), 64'd1);
        #2 ireset = 1'b0;
        #1;
        chk("async_reset", 64'({orow, oval, osop, oeop, orow_num, ocol, owshift, obshift,
                                omasked, obusy, odone}), 64'd0);
        #1 ireset = 1'b1;
        step();
        chk("post_reset_idle", 64'({obusy, oval}), 64'd0);
        run_pass(0, 22, 1'b0, 1'b0);
        chk("post_reset_count", 64'(n_desc), 64'd22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
